// File: rtl/digi_bist_pkg.sv
// digi_bist_pkg: shared types and helpers for the BIST harness.
//   state_e    - harness FSM states
//   lfsr_taps  - maximal-length Galois right-shift tap masks, widths 4..16
//   MISR_POLY  - signature compactor feedback polynomial
//   misr_next  - one MISR step for any signature width up to 32 bits
package digi_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] MISR_POLY = 32'h0000_1021;

  // Tap mask for next = (s >> 1) ^ (s[0] ? taps : 0).
  function automatic logic [15:0] lfsr_taps(input int unsigned width);
    case (width)
      4:       lfsr_taps = 16'h000C;
      5:       lfsr_taps = 16'h0014;
      6:       lfsr_taps = 16'h0030;
      7:       lfsr_taps = 16'h0060;
      8:       lfsr_taps = 16'h00B8;
      9:       lfsr_taps = 16'h0110;
      10:      lfsr_taps = 16'h0240;
      11:      lfsr_taps = 16'h0500;
      12:      lfsr_taps = 16'h0829;
      13:      lfsr_taps = 16'h100D;
      14:      lfsr_taps = 16'h2015;
      15:      lfsr_taps = 16'h6000;
      16:      lfsr_taps = 16'hD008;
      default: lfsr_taps = 16'h0000;
    endcase
  endfunction

  // Shift left, fold the outgoing MSB back through the polynomial, then
  // xor in the (zero-extended) response; result masked to sig_w bits.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] resp,
                                            input int unsigned sig_w);
    logic [31:0] mask;
    logic [31:0] nxt;
    mask = (sig_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << sig_w) - 32'd1);
    nxt  = sig << 1;
    if (sig[5'(sig_w - 1)]) nxt = nxt ^ MISR_POLY;
    misr_next = (nxt ^ resp) & mask;
  endfunction

endpackage

// File: rtl/digi_lfsr.sv
// digi_lfsr: Galois right-shift LFSR used as the BIST stimulus source.
//   clk, rst  - clock, synchronous active-high reset
//   load      - load the seed (a zero seed becomes all-ones)
//   advance   - step the register once
//   q         - current state; returns to 0 whenever neither load nor
//               advance is asserted, so it reads 0 outside a run
module digi_lfsr
  import digi_bist_pkg::*;
#(
  parameter int unsigned  W    = 8,
  parameter logic [W-1:0] SEED = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] TAPS     = W'(lfsr_taps(W));
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? '1 : SEED;

  always_ff @(posedge clk) begin
    if (rst)          q <= '0;
    else if (load)    q <= SEED_EFF;
    else if (advance) q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    else              q <= '0;
  end

endmodule

// File: rtl/digi_bist_harness.sv
// digi_bist_harness: self-test harness driving stimulus into the logic core
// and compacting its responses into a MISR signature.
//   clk, rst   - clock, synchronous active-high reset
//   start      - begins a run when sampled high in IDLE
//   mode       - 0: LFSR stimulus, 1: counting stimulus (BIST_MODE_COUNT_EN)
//   golden     - expected signature, sampled in the DONE cycle
//   resp_in    - core response, captured LAT cycles after each pattern
//   stim_out   - stimulus to the core, 0 outside RUN
//   busy       - high in RUN and FLUSH
//   done       - one-cycle pulse in DONE
//   pass       - signature matched golden, held until the next start
//   signature  - final MISR value, held until the next start
// Build option: define BIST_MODE_COUNT_EN to compile in the counting mode.
module digi_bist_harness
  import digi_bist_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       NUM_PAT = 256,
  parameter int unsigned       LAT     = 1,
  parameter logic [DATA_W-1:0] SEED    = DATA_W'(1),
  parameter int unsigned       SIG_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [SIG_W-1:0]  golden,
  input  logic [DATA_W-1:0] resp_in,
  output logic [DATA_W-1:0] stim_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam int unsigned CNT_W = ($clog2(NUM_PAT + 1) > 3) ? $clog2(NUM_PAT + 1) : 3;
  localparam int unsigned SR_W  = LAT + 1;
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(NUM_PAT - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [SR_W-1:0]   run_sr_q;
  logic [SIG_W-1:0]  sig_q;
  logic [DATA_W-1:0] lfsr_q;
  logic              load_c, advance_c, cap_c, busy_d, done_d, lfsr_load_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == RUN_LAST) state_d = (LAT == 0) ? DONE : FLUSH;
      FLUSH:   if (cnt_q == FLUSH_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control decode; busy/done are computed from the next state so the
  // registered outputs line up with the state they describe.
  always_comb begin
    load_c    = (state_q == IDLE) && start;
    advance_c = (state_q == RUN) && (state_d == RUN);
    cap_c     = run_sr_q[LAT];
    busy_d    = (state_d == RUN) || (state_d == FLUSH);
    done_d    = (state_d == DONE);
  end

  // Cycle counter within RUN and within FLUSH
  always_ff @(posedge clk) begin
    if (rst)                                       cnt_q <= '0;
    else if (state_d != state_q)                   cnt_q <= '0;
    else if (state_q == RUN || state_q == FLUSH)   cnt_q <= cnt_q + CNT_W'(1);
  end

  // Bit 0 mirrors "in RUN"; bit LAT is that flag delayed by LAT cycles
  always_ff @(posedge clk) begin
    if (rst) run_sr_q <= '0;
    else     run_sr_q <= SR_W'({run_sr_q, (state_d == RUN)});
  end

  // MISR and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q     <= '0;
      pass      <= 1'b0;
      signature <= '0;
    end else begin
      if (load_c)     sig_q <= '0;
      else if (cap_c) sig_q <= SIG_W'(misr_next(32'(sig_q), 32'(resp_in), SIG_W));

      if (load_c) begin
        pass      <= 1'b0;
        signature <= '0;
      end else if (state_q == DONE) begin
        pass      <= (sig_q == golden);
        signature <= sig_q;
      end
    end
  end

  // Status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  digi_lfsr #(
    .W    (DATA_W),
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load_c),
    .advance (advance_c),
    .q       (lfsr_q)
  );

`ifdef BIST_MODE_COUNT_EN
  logic              mode_q;
  logic [DATA_W-1:0] pat_q;

  always_ff @(posedge clk) begin
    if (rst)         mode_q <= 1'b0;
    else if (load_c) mode_q <= mode;
  end

  // Pattern counter; idles at 0 so it starts each run at pattern 0
  always_ff @(posedge clk) begin
    if (rst)                      pat_q <= '0;
    else if (advance_c && mode_q) pat_q <= pat_q + DATA_W'(1);
    else                          pat_q <= '0;
  end

  // The unselected source is held at 0, so the two can simply be merged
  assign lfsr_load_c = load_c && !mode;
  assign stim_out    = lfsr_q | pat_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign lfsr_load_c = load_c;
  assign stim_out    = lfsr_q;
`endif

endmodule

// File: tb/tb_digi_bist_harness.sv
// Bench for digi_bist_harness: two instances (LAT=1/NUM_PAT=256/SEED=1 and
// LAT=0/NUM_PAT=257/SEED=0) run side by side against a pattern/signature
// model built from the LFSR and MISR rules with plain arithmetic.
module tb_digi_bist_harness;

  localparam int NA = 256;
  localparam int LA = 1;
  localparam int NB = 257;
  localparam int LB = 0;
`ifdef BIST_MODE_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic        clk, rst, start, mode;
  logic [15:0] golden_a, golden_b, sig_out_a, sig_out_b;
  logic [7:0]  resp_a, resp_b, stim_a, stim_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  pat_a [NB];
  logic [7:0]  pat_b [NB];
  logic [7:0]  rsp_a [NB];
  logic [7:0]  rsp_b [NB];
  logic [7:0]  lfsr_first [5];
  logic [15:0] g_a, g_b, e_sig_a, e_sig_b;
  bit          e_pass_a, e_pass_b, use_count;

  digi_bist_harness #(.DATA_W(8), .NUM_PAT(NA), .LAT(LA), .SEED(8'h01), .SIG_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .golden(golden_a), .resp_in(resp_a),
    .stim_out(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_out_a));

  digi_bist_harness #(.DATA_W(8), .NUM_PAT(NB), .LAT(LB), .SEED(8'h00), .SIG_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .golden(golden_b), .resp_in(resp_b),
    .stim_out(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_out_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
    return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, r};
  endfunction

  // kind: 0 loopback, 1 bit0 of pattern 100 flipped, 2 random responses, 3 wrong golden
  task automatic build(input bit mode_v, input int kind);
    logic [7:0]  sa, sb, m;
    logic [15:0] fa, fb, ca, cb;
    use_count = mode_v && COUNT_EN;
    sa = 8'h01;
    sb = 8'hFF;
    fa = '0; fb = '0; ca = '0; cb = '0;
    for (int j = 0; j < NB; j++) begin
      if (use_count) begin
        pat_a[j] = 8'(j);
        pat_b[j] = 8'(j);
      end else begin
        pat_a[j] = sa;
        pat_b[j] = sb;
        sa = lfsr_step(sa);
        sb = lfsr_step(sb);
      end
      m = (kind == 1 && j == 100) ? 8'h01 : (kind == 2) ? 8'($urandom) : 8'h00;
      rsp_a[j] = pat_a[j] ^ m;
      rsp_b[j] = pat_b[j] ^ m;
      if (j < NA) begin
        fa = misr_step(fa, rsp_a[j]);
        ca = misr_step(ca, pat_a[j]);
      end
      fb = misr_step(fb, rsp_b[j]);
      cb = misr_step(cb, pat_b[j]);
    end
    e_sig_a = fa;
    e_sig_b = fb;
    g_a = (kind == 1) ? ca : fa;
    g_b = (kind == 1) ? cb : fb;
    if (kind == 3) begin
      g_a = g_a ^ 16'($urandom_range(1, 65535));
      g_b = g_b ^ 16'($urandom_range(1, 65535));
    end
    e_pass_a = (e_sig_a == g_a);
    e_pass_b = (e_sig_b == g_b);
  endtask

  task automatic do_run(input bit mode_v, input int kind, input int glitch_at, input int abort_at);
    bit ab;
    build(mode_v, kind);
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
      resp_a = 8'($urandom);
      resp_b = 8'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b1;
    mode  = mode_v;
    for (int c = 0; c <= 262; c++) begin
      if (c > 0) begin
        start = (c == glitch_at);
        mode  = 1'($urandom);
        rst   = (c == abort_at);
      end
      golden_a = (c == NA + LA + 1) ? g_a : 16'($urandom);
      golden_b = (c == NB + LB + 1) ? g_b : 16'($urandom);
      resp_a = (c >= 1 + LA && c <= NA + LA) ? rsp_a[c-1-LA] : 8'($urandom);
      resp_b = (c >= 1 + LB && c <= NB + LB) ? rsp_b[c-1-LB] : 8'($urandom);
      @(negedge clk);
      ab = (abort_at > 0) && (c > abort_at);
      check_eq($sformatf("stim_a c%0d", c), 32'(stim_a),
               (!ab && c >= 1 && c <= NA) ? 32'(pat_a[c-1]) : 32'd0);
      check_eq($sformatf("stim_b c%0d", c), 32'(stim_b),
               (!ab && c >= 1 && c <= NB) ? 32'(pat_b[c-1]) : 32'd0);
      check_eq($sformatf("busy_a c%0d", c), 32'(busy_a), 32'(!ab && c >= 1 && c <= NA + LA));
      check_eq($sformatf("busy_b c%0d", c), 32'(busy_b), 32'(!ab && c >= 1 && c <= NB + LB));
      check_eq($sformatf("done_a c%0d", c), 32'(done_a), 32'(!ab && c == NA + LA + 1));
      check_eq($sformatf("done_b c%0d", c), 32'(done_b), 32'(!ab && c == NB + LB + 1));
      if (!use_count && c >= 1 && c <= 5)
        check_eq($sformatf("lfsr_seq c%0d", c), 32'(stim_a), 32'(lfsr_first[c-1]));
      if (!ab && c == NA + LA + 2) begin
        check_eq("pass_a", 32'(pass_a), 32'(e_pass_a));
        check_eq("sig_a", 32'(sig_out_a), 32'(e_sig_a));
      end
      if (!ab && c == NB + LB + 2) begin
        check_eq("pass_b", 32'(pass_b), 32'(e_pass_b));
        check_eq("sig_b", 32'(sig_out_b), 32'(e_sig_b));
      end
      if (ab && c == 262) begin
        check_eq("abort pass_a", 32'(pass_a), 32'd0);
        check_eq("abort sig_a", 32'(sig_out_a), 32'd0);
        check_eq("abort pass_b", 32'(pass_b), 32'd0);
        check_eq("abort sig_b", 32'(sig_out_b), 32'd0);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    lfsr_first[0] = 8'h01; lfsr_first[1] = 8'hB8; lfsr_first[2] = 8'h5C;
    lfsr_first[3] = 8'h2E; lfsr_first[4] = 8'h17;
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    golden_a = '0; golden_b = '0; resp_a = '0; resp_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst stim_a", 32'(stim_a), 32'd0);
    check_eq("rst busy_a", 32'(busy_a), 32'd0);
    check_eq("rst done_a", 32'(done_a), 32'd0);
    check_eq("rst pass_a", 32'(pass_a), 32'd0);
    check_eq("rst sig_a", 32'(sig_out_a), 32'h0000);
    check_eq("rst stim_b", 32'(stim_b), 32'd0);
    check_eq("rst busy_b", 32'(busy_b), 32'd0);
    check_eq("rst sig_b", 32'(sig_out_b), 32'h0000);

    do_run(1'b0, 0, 0, 0);     // loopback, pass
    do_run(1'b0, 1, 0, 0);     // corrupted pattern 100
    do_run(1'b0, 0, 50, 0);    // stray start mid-run
    do_run(1'b0, 0, 0, 120);   // reset mid-run
    do_run(1'b1, 0, 0, 0);     // counting mode (LFSR when not compiled in)
    do_run(1'b1, 2, 258, 0);   // random responses, start during DONE
    do_run(1'b0, 3, 0, 0);     // wrong golden
    for (int r = 0; r < 3; r++)
      do_run(1'($urandom), $urandom_range(0, 3), 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
